addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//   Parametrised, pipelined add/subtract unit for the CPU datapath.
//   Replaces the fixed 4-bit ripple adder with WIDTH-bit operands.
//   The carry chain is split into STAGES slices, with one register stage per slice.
//   Valid/ready handshakes on both sides; full throughput of 1 op/cycle.
//   Produces carry, signed-overflow and zero flags for the ALU flag register.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; must be divisible by STAGES
//   STAGES  2   pipeline depth; SLICE = WIDTH/STAGES bits resolved per stage
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit can accept a beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (sub=1: 1 = plain subtract, 0 = borrow chaining)
//   sub        in   1      0: a+b+cin; 1: a+~b+cin
//   sat        in   1      saturate on signed overflow (present only with ADDSUB_SAT_EN)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry-into-MSB ^ carry-out
//   zero       out  1      sum == 0 (after saturation, if applied)
// BEHAVIOUR
//   - Reset (async, rst=1): all stage valids=0, all data regs=0; out_valid/sum/cout/ovf/zero=0.
//     Any in-flight ops are discarded; the first accept occurs on the first clk edge after rst falls.
//   - Accept on in_valid&in_ready; emit on out_valid&out_ready. Inputs are sampled only on accept.
//   - Stage k (0..STAGES-1) holds v_k and computes bits [k*SLICE +: SLICE] from the registered carry of stage k-1.
//     Stage 0 computes from cin. Lower result bits and upper operand bits travel with the op.
//     There is no combinational carry path across a stage boundary.
//   - Stage advance: en_k = !v_k | en_{k+1}; en_STAGES = out_ready; in_ready = en_0.
//     in_ready is combinational from out_ready; there are no bubbles when out_ready=1.
//   - Latency: STAGES cycles from accept to out_valid when unstalled. STAGES=1 is legal (single register).
//   - Stall: when out_ready=0 with the pipe full, all regs hold and in_ready=0.
//     The pipe holds exactly STAGES ops; no loss, duplication or reordering.
//   - Simultaneous accept and emit on a full pipe is allowed (shift-through).
//   - Flags are computed in the last stage from the final carries; zero is computed on the post-saturation sum.
//   - Output regs remain stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//   ADDSUB_SAT_EN defined:
//     - Port sat exists; the sat value travels with the op.
//     - If sat=1 and ovf=1, sum is clamped to 0111..1 on positive overflow and 1000..0 on negative overflow.
//     - ovf still reports 1; cout is unchanged (raw).
//   ADDSUB_SAT_EN undefined: port sat is absent; results always wrap modulo 2^WIDTH.
// STRUCTURE
//   - Package addsub_pkg: localparams for op encoding (OP_ADD=0, OP_SUB=1) and the flag-struct typedef
//     {cout, ovf, zero} shared with the ALU flag register.
//   - Sub-module addsub_slice: SLICE-bit combinational adder (b pre-inverted for sub) returning sum,
//     carry-out and carry-into-MSB. It is instanced once per stage inside a generate loop.
//     The registers stay in addsub_pipe.
// TESTING (WIDTH=8, STAGES=2 unless noted; out_ready=1 unless noted)
//   1. a=FF b=01 cin=0 sub=0 -> 2 cycles later: sum=00 cout=1 ovf=0 zero=1.
//   2. a=7F b=01 add -> sum=80 ovf=1 cout=0. With ADDSUB_SAT_EN and sat=1 -> sum=7F ovf=1 zero=0.
//   3. a=05 b=07 sub=1 cin=1 -> sum=FE cout=0 ovf=0. a=80 b=01 sub=1 cin=1 -> sum=7F ovf=1 (sat=1: sum=80).
//   4. 5 back-to-back ops; out_ready=0 from cycle 2 for 4 cycles -> in_ready=0 once 2 ops are held;
//      all 5 results emerge in order, each once.
//   5. rst pulsed while 2 ops are in flight -> out_valid=0 and sum=0 immediately (async);
//      no stale result is emitted after release.
//   6. Random regression vs a behavioural model for (WIDTH,STAGES) = (8,1), (16,4) and (32,2),
//      with random valid/ready throttling.

Source files
------------

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the pipelined add/subtract unit and the ALU flag
//   register that consumes its flags.
//
//   Contents
//     OP_ADD / OP_SUB   encoding of the 'sub' operation select input
//     addsub_flags_t    {cout, ovf, zero} flag bundle
//     signedOverflow    two's-complement overflow from the MSB carries
//
//   Configuration macro: ADDSUB_SAT_EN (used by addsub_pipe, not here).
// ---------------------------------------------------------------------------
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Flag bundle in the same field order the ALU flag register uses.
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } addsub_flags_t;

  // A signed result overflows exactly when the carry into the sign bit
  // disagrees with the carry out of it.
  function automatic logic signedOverflow(input logic carryIntoMsb,
                                          input logic carryOut);
    return carryIntoMsb ^ carryOut;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// ---------------------------------------------------------------------------
// addsub_slice
//   Purely combinational SLICE-bit adder used for one pipeline stage of
//   addsub_pipe. Subtraction is handled by the caller, which presents an
//   already inverted b_i together with the appropriate carry-in.
//
//   Ports
//     a_i     in   SLICE  operand A slice
//     b_i     in   SLICE  operand B slice (pre-inverted for subtract)
//     c_i     in   1      carry into bit 0 of the slice
//     sum_o   out  SLICE  slice sum
//     cout_o  out  1      carry out of the slice MSB
//     cmsb_o  out  1      carry into the slice MSB
// ---------------------------------------------------------------------------
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE:0] total;

  // One extra bit of headroom captures the carry out of the slice.
  assign total  = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
  assign sum_o  = total[SLICE-1:0];
  assign cout_o = total[SLICE];

  // The sum bit at the MSB is a ^ b ^ carry-in, so the carry into the MSB
  // can be recovered without exposing the internal carry chain.
  assign cmsb_o = sum_o[SLICE-1] ^ a_i[SLICE-1] ^ b_i[SLICE-1];

endmodule

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
//   Pipelined WIDTH-bit add/subtract unit with valid/ready handshakes on both
//   sides. The carry chain is cut into STAGES slices of SLICE = WIDTH/STAGES
//   bits; each slice sits behind its own register stage so no carry crosses a
//   stage boundary combinationally. Throughput is one op per cycle and the
//   latency is STAGES cycles when downstream is ready.
//
//   Parameters
//     WIDTH   operand/result width, must be a multiple of STAGES
//     STAGES  pipeline depth (1 is a single register stage)
//
//   Ports
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      operand beat valid
//     in_ready   out  1      unit can take a beat this cycle
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in (for subtract, 1 = plain subtract)
//     sub        in   1      OP_ADD: a+b+cin, OP_SUB: a+~b+cin
//     sat        in   1      saturate on signed overflow (ADDSUB_SAT_EN only)
//     out_valid  out  1      result beat valid
//     out_ready  in   1      downstream takes the result
//     sum        out  WIDTH  result (clamped when saturating)
//     cout       out  1      raw carry out of the MSB
//     ovf        out  1      signed overflow
//     zero       out  1      sum == 0, evaluated after any clamping
//
//   Configuration macro
//     ADDSUB_SAT_EN  adds the 'sat' port; when sat=1 and the op overflows,
//                    the sum clamps to the largest/smallest signed value.
//                    Without it results always wrap modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;

  // Per-stage registers. Each stage carries the full operands, the partial
  // sum built so far and the carry out of its own slice.
  logic             stageValid_q [STAGES];
  logic [WIDTH-1:0] opA_q        [STAGES];
  logic [WIDTH-1:0] opB_q        [STAGES];
  logic [WIDTH-1:0] partSum_q    [STAGES];
  logic             carry_q      [STAGES];
`ifdef ADDSUB_SAT_EN
  logic             sat_q        [STAGES];
`endif
  addsub_flags_t    flags_q;

  // Combinational results of each stage's slice adder.
  logic [SLICE-1:0] sliceSum  [STAGES];
  logic             sliceCout [STAGES];
  logic             sliceCmsb [STAGES];

  logic [STAGES-1:0] stageEn;
  logic [WIDTH-1:0]  bEff;

  // Operand B is inverted once at the input for subtraction; later stages
  // simply consume the stored, already-inverted word.
  assign bEff = (sub == OP_SUB) ? ~b : b;

  // A stage may load when it is empty or when every stage downstream of it
  // will also move this cycle. Walking from the output back towards the
  // input, the stage can advance as soon as any hole exists at or beyond
  // it, or the consumer is taking the result. This keeps the ready chain
  // free of bubbles while out_ready stays high.
  always_comb begin
    logic roomAhead;
    stageEn   = '0;
    roomAhead = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      roomAhead  = roomAhead | ~stageValid_q[k];
      stageEn[k] = roomAhead;
    end
  end

  assign in_ready = stageEn[0];

  for (genvar k = 0; k < STAGES; k++) begin : gStage

    logic             stageInValid;
    logic [WIDTH-1:0] stageInA;
    logic [WIDTH-1:0] stageInB;
    logic [WIDTH-1:0] stageInSum;
    logic             stageInCarry;
`ifdef ADDSUB_SAT_EN
    logic             stageInSat;
`endif
    logic [WIDTH-1:0] sumRaw;
    logic [WIDTH-1:0] stageSum_d;

    if (k == 0) begin : gHead
      assign stageInValid = in_valid;
      assign stageInA     = a;
      assign stageInB     = bEff;
      assign stageInSum   = '0;
      assign stageInCarry = cin;
`ifdef ADDSUB_SAT_EN
      assign stageInSat   = sat;
`endif
    end else begin : gBody
      assign stageInValid = stageValid_q[k-1];
      assign stageInA     = opA_q[k-1];
      assign stageInB     = opB_q[k-1];
      assign stageInSum   = partSum_q[k-1];
      assign stageInCarry = carry_q[k-1];
`ifdef ADDSUB_SAT_EN
      assign stageInSat   = sat_q[k-1];
`endif
    end

    addsub_slice #(
      .SLICE (SLICE)
    ) uSlice (
      .a_i    (stageInA[k*SLICE +: SLICE]),
      .b_i    (stageInB[k*SLICE +: SLICE]),
      .c_i    (stageInCarry),
      .sum_o  (sliceSum[k]),
      .cout_o (sliceCout[k]),
      .cmsb_o (sliceCmsb[k])
    );

    // Splice this stage's slice into the partial sum handed down from the
    // previous stage; bits above this slice are still unresolved.
    always_comb begin
      sumRaw                     = stageInSum;
      sumRaw[k*SLICE +: SLICE]   = sliceSum[k];
    end

    if (k == STAGES - 1) begin : gTail
      logic ovfRaw;

      assign ovfRaw = signedOverflow(sliceCmsb[k], sliceCout[k]);

`ifdef ADDSUB_SAT_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

      // An overflowing result has the wrong sign bit: a negative-looking
      // wrapped sum means the true value was too large, and vice versa.
      assign stageSum_d = (stageInSat & ovfRaw)
                          ? (sumRaw[WIDTH-1] ? SAT_MAX : SAT_MIN)
                          : sumRaw;
`else
      assign stageSum_d = sumRaw;
`endif

      // Flags are produced only once the final carries are known, and zero
      // looks at the sum that will actually be presented downstream.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flags_q <= '0;
        end else if (stageEn[k] && stageInValid) begin
          flags_q.cout <= sliceCout[k];
          flags_q.ovf  <= ovfRaw;
          flags_q.zero <= (stageSum_d == '0);
        end
      end
    end else begin : gMid
      assign stageSum_d = sumRaw;
    end

    // Stage register. The valid bit follows the stage enable; data only
    // loads for a real op so outputs stay put across bubbles and stalls.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stageValid_q[k] <= 1'b0;
        opA_q[k]        <= '0;
        opB_q[k]        <= '0;
        partSum_q[k]    <= '0;
        carry_q[k]      <= 1'b0;
`ifdef ADDSUB_SAT_EN
        sat_q[k]        <= 1'b0;
`endif
      end else if (stageEn[k]) begin
        stageValid_q[k] <= stageInValid;
        if (stageInValid) begin
          opA_q[k]     <= stageInA;
          opB_q[k]     <= stageInB;
          partSum_q[k] <= stageSum_d;
          carry_q[k]   <= sliceCout[k];
`ifdef ADDSUB_SAT_EN
          sat_q[k]     <= stageInSat;
`endif
        end
      end
    end

  end

  assign out_valid = stageValid_q[STAGES-1];
  assign sum       = partSum_q[STAGES-1];
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe
//   Drives four addsub_pipe instances: (8,2), (8,1), (16,4) and (32,2).
//   Directed cases run on the (8,2) instance; the random regression runs on
//   all four together, checked against a plain-arithmetic reference.
//   Build with ADDSUB_SAT_EN defined to exercise saturation.
// ---------------------------------------------------------------------------
module tb_addsub_pipe;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ivR, orR, cinR, subR, satR;
  logic [31:0] aR [4];
  logic [31:0] bR [4];
  wire  [3:0]  irW, ovW, coutW, ovfW, zeroW;
  wire  [7:0]  s0, s1;
  wire  [15:0] s2;
  wire  [31:0] s3;

  int   checks = 0;
  int   errors = 0;
  expT  q [4][$];
  logic [3:0] tookLast;
  logic [3:0] irSeen;
  int   emitCnt [4];

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(8), .STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(ivR[0]), .in_ready(irW[0]),
    .a(aR[0][7:0]), .b(bR[0][7:0]), .cin(cinR[0]), .sub(subR[0]),
`ifdef ADDSUB_SAT_EN
    .sat(satR[0]),
`endif
    .out_valid(ovW[0]), .out_ready(orR[0]), .sum(s0),
    .cout(coutW[0]), .ovf(ovfW[0]), .zero(zeroW[0]));

  addsub_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(ivR[1]), .in_ready(irW[1]),
    .a(aR[1][7:0]), .b(bR[1][7:0]), .cin(cinR[1]), .sub(subR[1]),
`ifdef ADDSUB_SAT_EN
    .sat(satR[1]),
`endif
    .out_valid(ovW[1]), .out_ready(orR[1]), .sum(s1),
    .cout(coutW[1]), .ovf(ovfW[1]), .zero(zeroW[1]));

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(ivR[2]), .in_ready(irW[2]),
    .a(aR[2][15:0]), .b(bR[2][15:0]), .cin(cinR[2]), .sub(subR[2]),
`ifdef ADDSUB_SAT_EN
    .sat(satR[2]),
`endif
    .out_valid(ovW[2]), .out_ready(orR[2]), .sum(s2),
    .cout(coutW[2]), .ovf(ovfW[2]), .zero(zeroW[2]));

  addsub_pipe #(.WIDTH(32), .STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(ivR[3]), .in_ready(irW[3]),
    .a(aR[3]), .b(bR[3]), .cin(cinR[3]), .sub(subR[3]),
`ifdef ADDSUB_SAT_EN
    .sat(satR[3]),
`endif
    .out_valid(ovW[3]), .out_ready(orR[3]), .sum(s3),
    .cout(coutW[3]), .ovf(ovfW[3]), .zero(zeroW[3]));

  // Width of each instance, used by the reference model and the stimulus.
  function automatic int widthOf(input int i);
    case (i)
      0, 1:    return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] sumOf(input int i);
    case (i)
      0:       return {24'd0, s0};
      1:       return {24'd0, s1};
      2:       return {16'd0, s2};
      default: return s3;
    endcase
  endfunction

  function automatic logic satEff(input int i);
`ifdef ADDSUB_SAT_EN
    return satR[i];
`else
    return 1'b0 & satR[i];
`endif
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result signs,
  // clamp direction from the sign shared by both operands.
  function automatic expT refOp(input int w, input logic [31:0] av,
                                input logic [31:0] bv, input logic c,
                                input logic s, input logic st);
    expT r;
    logic [63:0] mask, bE, full;
    logic sa, sb;
    mask   = (64'd1 << w) - 64'd1;
    bE     = s ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
    full   = ({32'd0, av} & mask) + bE + {63'd0, c};
    r.sum  = 32'(full & mask);
    r.cout = full[w];
    sa     = av[w-1];
    sb     = bE[w-1];
    r.ovf  = (sa == sb) && (r.sum[w-1] != sa);
    if (st && r.ovf)
      r.sum = sa ? 32'(64'd1 << (w - 1)) : 32'(mask >> 1);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic newOp(input int i);
    logic [63:0] m;
    m = (64'd1 << widthOf(i)) - 64'd1;
    aR[i]   = $urandom & 32'(m);
    bR[i]   = $urandom & 32'(m);
    cinR[i] = 1'($urandom);
    subR[i] = 1'($urandom);
    satR[i] = 1'($urandom);
  endtask

  // One clock cycle with scoreboard bookkeeping at the falling edge.
  task automatic runCycle();
    expT e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      irSeen[i] = irW[i];
      if (ovW[i] && orR[i]) begin
        emitCnt[i]++;
        if (q[i].size() == 0) begin
          check($sformatf("dut%0d unexpected emit", i), 64'd1, 64'd0);
        end else begin
          e = q[i].pop_front();
          check($sformatf("dut%0d sum", i), sumOf(i), e.sum);
          check($sformatf("dut%0d flags", i), {coutW[i], ovfW[i], zeroW[i]},
                {e.cout, e.ovf, e.zero});
        end
      end
      tookLast[i] = ivR[i] && irW[i];
      if (tookLast[i])
        q[i].push_back(refOp(widthOf(i), aR[i], bR[i], cinR[i], subR[i], satEff(i)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyRandom(input int pctValid, input int pctReady);
    for (int i = 0; i < 4; i++) begin
      if (!ivR[i] || tookLast[i]) begin
        newOp(i);
        ivR[i] = ($urandom_range(99) < pctValid);
      end
      orR[i] = ($urandom_range(99) < pctReady);
    end
  endtask

  // Single directed op on the (8,2) instance; returns one cycle after accept.
  task automatic applyStimulus(input logic [7:0] aa, input logic [7:0] bb,
                               input logic c, input logic s, input logic st);
    ivR     = 4'b0001;
    orR     = 4'b1111;
    aR[0]   = {24'd0, aa};
    bR[0]   = {24'd0, bb};
    cinR[0] = c;
    subR[0] = s;
    satR[0] = st;
    @(negedge clk);
    check("directed in_ready", irW[0], 1);
    @(posedge clk);
    #1;
    ivR[0] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expSum,
                             input logic expCout, input logic expOvf,
                             input logic expZero);
    int lat;
    lat = 1;
    while (!ovW[0] && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " sum"}, s0, expSum);
    check({tag, " flags"}, {coutW[0], ovfW[0], zeroW[0]}, {expCout, expOvf, expZero});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    ivR = '0; orR = '1; cinR = '0; subR = '0; satR = '0; tookLast = '0;
    irSeen = '0;
    for (int i = 0; i < 4; i++) begin
      aR[i] = '0; bR[i] = '0; emitCnt[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", ovW, 4'b0000);
    check("reset sum", s0, 8'h00);
    check("reset flags", {coutW[0], ovfW[0], zeroW[0]}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Carry out with zero result
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("t1 FF+01", 8'h00, 1'b1, 1'b0, 1'b1);

    // Positive overflow, wrapping and (optionally) saturating
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 7F+01", 8'h80, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    checkOutput("t2 7F+01 sat", 8'h7F, 1'b0, 1'b1, 1'b0);
`endif

    // Subtraction: borrow, negative overflow, exact zero
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("t3 05-07", 8'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    checkOutput("t3 80-01", 8'h7F, 1'b1, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
    checkOutput("t3 80-01 sat", 8'h80, 1'b1, 1'b1, 1'b0);
`endif
    applyStimulus(8'h33, 8'h33, 1'b1, 1'b1, 1'b0);
    checkOutput("t3 33-33", 8'h00, 1'b1, 1'b0, 1'b1);

    ivR = '0;
    orR = '1;
    repeat (3) @(posedge clk);
    #1;

    // Five back-to-back ops with a four-cycle downstream stall
    sent = 0;
    tookLast = '0;
    emitCnt[0] = 0;
    for (int c = 0; c < 20; c++) begin
      if (!ivR[0] || tookLast[0]) begin
        if (sent < 5) begin
          newOp(0);
          ivR[0] = 1'b1;
          sent++;
        end else begin
          ivR[0] = 1'b0;
        end
      end
      orR[0] = !(c >= 2 && c < 6);
      runCycle();
      if (c >= 2 && c < 6) begin
        check("t4 in_ready while full", irSeen[0], 1'b0);
        check("t4 out_valid while held", ovW[0], 1'b1);
      end
    end
    check("t4 emitted count", emitCnt[0], 5);
    check("t4 queue drained", q[0].size(), 0);

    // Reset with two ops in flight
    orR = '1;
    for (int c = 0; c < 2; c++) begin
      newOp(0);
      ivR[0] = 1'b1;
      runCycle();
    end
    ivR = '0;
    check("t5 op in flight", ovW[0], 1'b1);
    rst = 1'b1;
    #1;
    check("t5 async out_valid", ovW, 4'b0000);
    check("t5 async sum", s0, 8'h00);
    check("t5 async flags", {coutW[0], ovfW[0], zeroW[0]}, 3'b000);
    for (int i = 0; i < 4; i++) q[i].delete();
    tookLast = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      runCycle();
      check("t5 no stale result", ovW[0], 1'b0);
    end

    // Random regression on all four configurations with throttling
    for (int i = 0; i < 4; i++) emitCnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      applyRandom(70, 70);
      runCycle();
    end
    ivR = '0;
    orR = '1;
    for (int c = 0; c < 12; c++) runCycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d queue drained", i), q[i].size(), 0);
      check($sformatf("dut%0d traffic seen", i), emitCnt[i] > 500, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
